// File: rtl/mem_pkg.sv
// Shared types and helpers for the unified instruction/data memory subsystem.
package mem_pkg;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } chan_t;

  localparam int READ_LAT_MAX = 4;

  // Byte address to word index: drop the byte offset, keep only the storage-sized field.
  function automatic logic [63:0] word_idx(input logic [63:0] addr, input int unsigned depth_log2);
    return (addr >> 2) & ((64'd1 << depth_log2) - 64'd1);
  endfunction

endpackage

// File: rtl/sram_bank.sv
// Single-port storage bank with byte-lane writes and a one-cycle registered read.
module sram_bank #(
  parameter  int DATA_W     = 32,
  parameter  int DEPTH_LOG2 = 14,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [BE_W-1:0]       we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Read data holds when the bank is idle so downstream stages see a stable word.
  always_comb begin
    rdata_d = rdata_q;
    if (en) rdata_d = mem_q[idx];
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < BE_W; k++) begin
        if (we[k]) mem_q[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dual_port_mem_arb.sv
// Instruction and data channels sharing one single-port bank through a
// round-robin arbiter, with a tagged read pipeline of configurable latency.
module dual_port_mem_arb
  import mem_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int ADDR_W     = 32,
  parameter  int DEPTH_LOG2 = 14,
  parameter  int READ_LAT   = 1,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [BE_W-1:0]   d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata
);

  if (READ_LAT < 1 || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
    $error("dual_port_mem_arb: READ_LAT must be in 1..%0d", READ_LAT_MAX);
  end
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("dual_port_mem_arb: DATA_W must be a multiple of 8");
  end

  chan_t                 last_gnt_d, last_gnt_q;
  logic                  bank_en;
  logic [BE_W-1:0]       bank_we;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DEPTH_LOG2-1:0] bank_idx;
  logic [DATA_W-1:0]     bank_rdata;
  logic                  vld_p0_d, vld_p0_q;
  chan_t                 tag_p0_d, tag_p0_q;

  // Arbitration: the channel that did not win last time wins a conflict.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (i_req && d_req) begin
        if (last_gnt_q == INSTR) d_gnt = 1'b1;
        else                     i_gnt = 1'b1;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
    last_gnt_d = last_gnt_q;
    if (i_gnt)      last_gnt_d = INSTR;
    else if (d_gnt) last_gnt_d = DATA;
  end

  always_comb begin
    bank_en  = i_gnt | d_gnt;
    bank_we  = d_gnt ? d_we : '0;
    sel_addr = d_gnt ? d_addr : i_addr;
    bank_idx = DEPTH_LOG2'(word_idx(64'(sel_addr), DEPTH_LOG2));
    vld_p0_d = i_gnt | (d_gnt && (d_we == '0));
    tag_p0_d = d_gnt ? DATA : INSTR;
  end

  sram_bank #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_bank (
    .clk   (clk),
    .en    (bank_en),
    .we    (bank_we),
    .idx   (bank_idx),
    .wdata (d_wdata),
    .rdata (bank_rdata)
  );

  // Stage p0: bank output cycle, one cycle after the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= INSTR;
      vld_p0_q   <= 1'b0;
      tag_p0_q   <= INSTR;
    end else begin
      last_gnt_q <= last_gnt_d;
      vld_p0_q   <= vld_p0_d;
      tag_p0_q   <= tag_p0_d;
    end
  end

  logic              vld_at  [READ_LAT];
  chan_t             tag_at  [READ_LAT];
  logic [DATA_W-1:0] data_at [READ_LAT];

  assign vld_at[0]  = vld_p0_q;
  assign tag_at[0]  = tag_p0_q;
  assign data_at[0] = bank_rdata;

  // Stages p1..p(READ_LAT-1): extra delay, valid and tag travel with the word.
  for (genvar k = 1; k < READ_LAT; k++) begin : g_stage
    logic              vld_d, vld_q;
    chan_t             tag_d, tag_q;
    logic [DATA_W-1:0] data_d, data_q;

    always_comb begin
      vld_d  = vld_at[k-1];
      tag_d  = tag_at[k-1];
      data_d = data_at[k-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        tag_q <= INSTR;
      end else begin
        vld_q <= vld_d;
        tag_q <= tag_d;
      end
      data_q <= data_d;
    end

    assign vld_at[k]  = vld_q;
    assign tag_at[k]  = tag_q;
    assign data_at[k] = data_q;
  end

  logic              vld_last;
  chan_t             tag_last;
  logic [DATA_W-1:0] data_last;
  logic [DATA_W-1:0] i_rdata_d, i_rdata_q, d_rdata_d, d_rdata_q;

  assign vld_last  = vld_at[READ_LAT-1];
  assign tag_last  = tag_at[READ_LAT-1];
  assign data_last = data_at[READ_LAT-1];

  // A response still in flight while rst is high is dropped, not delivered.
  always_comb begin
    i_rvalid  = !rst && vld_last && (tag_last == INSTR);
    d_rvalid  = !rst && vld_last && (tag_last == DATA);
    i_rdata   = i_rvalid ? data_last : i_rdata_q;
    d_rdata   = d_rvalid ? data_last : d_rdata_q;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_dual_port_mem_arb.sv
// Directed bench: instance a (READ_LAT=1, full depth), instance b (READ_LAT=3, DEPTH_LOG2=4).
module tb_dual_port_mem_arb;

  logic        clk = 1'b0;
  int          checks = 0;
  int          failures = 0;

  logic        rst, i_req, i_gnt, i_rvalid, d_req, d_gnt, d_rvalid;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_we;

  logic        b_rst, b_i_req, b_i_gnt, b_i_rvalid, b_d_req, b_d_gnt, b_d_rvalid;
  logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [3:0]  b_d_we;

  always #5 clk = ~clk;

  dual_port_mem_arb #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(14), .READ_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata)
  );

  dual_port_mem_arb #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(4), .READ_LAT(3)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata)
  );

  task automatic idle_a();
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic idle_b();
    b_i_req = 1'b0; b_i_addr = '0; b_d_req = 1'b0; b_d_we = '0; b_d_addr = '0; b_d_wdata = '0;
  endtask

  task automatic do_reset_a();
    @(negedge clk); rst = 1'b1; idle_a();
    @(negedge clk);
    @(negedge clk); rst = 1'b0; #1;
  endtask

  task automatic do_reset_b();
    @(negedge clk); b_rst = 1'b1; idle_b();
    @(negedge clk);
    @(negedge clk); b_rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; i_req = 1'b1; d_req = 1'b1; #1;
    checks++; if ({i_gnt, d_gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b want=00", {i_gnt, d_gnt}); end
    @(negedge clk); #1;
    checks++; if ({i_gnt, d_gnt, i_rvalid, d_rvalid} !== 4'b0000) begin failures++; $display("FAIL reset_ctrl got=%b want=0000", {i_gnt, d_gnt, i_rvalid, d_rvalid}); end
    checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h want=0/0", i_rdata, d_rdata); end
    @(negedge clk); rst = 1'b0; idle_a(); #1;
    checks++; if ({i_rvalid, d_rvalid} !== 2'b00 || i_rdata !== 32'h0) begin failures++; $display("FAIL reset_release got=%b %h want=00 0", {i_rvalid, d_rvalid}, i_rdata); end
  endtask

  task automatic test_ifetch();
    @(negedge clk); d_req = 1'b1; d_we = 4'hF; d_addr = 32'h0; d_wdata = 32'h0000_0013; #1;
    checks++; if ({i_gnt, d_gnt} !== 2'b01) begin failures++; $display("FAIL preload_gnt got=%b want=01", {i_gnt, d_gnt}); end
    @(negedge clk); idle_a(); i_req = 1'b1; i_addr = 32'h0; #1;
    checks++; if ({i_gnt, d_gnt, d_rvalid} !== 3'b100) begin failures++; $display("FAIL ifetch_gnt got=%b want=100", {i_gnt, d_gnt, d_rvalid}); end
    @(negedge clk); idle_a(); #1;
    checks++; if ({i_rvalid, d_rvalid} !== 2'b10 || i_rdata !== 32'h0000_0013) begin failures++; $display("FAIL ifetch_resp got=%b %h want=10 00000013", {i_rvalid, d_rvalid}, i_rdata); end
    @(negedge clk); #1;
    checks++; if (i_rvalid !== 1'b0 || i_rdata !== 32'h0000_0013) begin failures++; $display("FAIL ifetch_hold got=%b %h want=0 00000013", i_rvalid, i_rdata); end
  endtask

  task automatic test_byte_enable();
    @(negedge clk); d_req = 1'b1; d_we = 4'b1111; d_addr = 32'h10; d_wdata = 32'hAABB_CCDD; #1;
    @(negedge clk); d_we = 4'b0010; d_wdata = 32'h0000_1100; #1;
    checks++; if (d_gnt !== 1'b1 || d_rvalid !== 1'b0) begin failures++; $display("FAIL be_write got=%b%b want=10", d_gnt, d_rvalid); end
    @(negedge clk); d_we = 4'b0000; d_wdata = 32'h0; #1;
    checks++; if (d_gnt !== 1'b1 || d_rvalid !== 1'b0) begin failures++; $display("FAIL be_read_gnt got=%b%b want=10", d_gnt, d_rvalid); end
    @(negedge clk); idle_a(); #1;
    checks++; if ({d_rvalid, i_rvalid} !== 2'b10 || d_rdata !== 32'hAABB_11DD) begin failures++; $display("FAIL be_read got=%b %h want=10 aabb11dd", {d_rvalid, i_rvalid}, d_rdata); end
  endtask

  task automatic test_contention();
    logic exp_d;
    do_reset_a();
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6) begin
        i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_addr = 32'h10; d_we = '0;
      end else idle_a();
      #1;
      exp_d = (k % 2 == 0);
      if (k < 6) begin
        checks++; if ({i_gnt, d_gnt} !== {~exp_d, exp_d}) begin failures++; $display("FAIL rr_gnt c%0d got=%b want=%b", k, {i_gnt, d_gnt}, {~exp_d, exp_d}); end
      end
      if (k > 0) begin
        checks++;
        if (!exp_d) begin
          if ({i_rvalid, d_rvalid} !== 2'b01 || d_rdata !== 32'hAABB_11DD) begin failures++; $display("FAIL rr_resp c%0d got=%b %h want=01 aabb11dd", k, {i_rvalid, d_rvalid}, d_rdata); end
        end else begin
          if ({i_rvalid, d_rvalid} !== 2'b10 || i_rdata !== 32'h0000_0013) begin failures++; $display("FAIL rr_resp c%0d got=%b %h want=10 00000013", k, {i_rvalid, d_rvalid}, i_rdata); end
        end
      end else begin
        checks++; if ({i_rvalid, d_rvalid} !== 2'b00) begin failures++; $display("FAIL rr_first got=%b want=00", {i_rvalid, d_rvalid}); end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle_a(); d_req = 1'b1; d_addr = 32'h10; #1;
    checks++; if (d_gnt !== 1'b1) begin failures++; $display("FAIL mid_read_gnt got=%b want=1", d_gnt); end
    @(negedge clk); rst = 1'b1; d_req = 1'b1; d_we = 4'hF; d_addr = 32'h10; d_wdata = 32'h0; #1;
    checks++; if ({d_gnt, d_rvalid, i_rvalid} !== 3'b000) begin failures++; $display("FAIL mid_rst got=%b want=000", {d_gnt, d_rvalid, i_rvalid}); end
    @(negedge clk); rst = 1'b0; idle_a(); #1;
    checks++; if ({d_rvalid, i_rvalid} !== 2'b00 || d_rdata !== 32'h0) begin failures++; $display("FAIL mid_after got=%b %h want=00 0", {d_rvalid, i_rvalid}, d_rdata); end
    @(negedge clk); i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_addr = 32'h10; #1;
    checks++; if ({i_gnt, d_gnt} !== 2'b01) begin failures++; $display("FAIL mid_first_conflict got=%b want=01", {i_gnt, d_gnt}); end
    @(negedge clk); idle_a(); #1;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hAABB_11DD) begin failures++; $display("FAIL mid_no_write got=%b %h want=1 aabb11dd", d_rvalid, d_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words[0] = 32'h1111_1111; words[1] = 32'h2222_2222; words[2] = 32'h3333_3333;
    do_reset_b();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); b_d_req = 1'b1; b_d_we = 4'hF; b_d_addr = 32'(4 * k); b_d_wdata = words[k]; #1;
    end
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk); idle_b();
      if (c <= 3) begin b_i_req = 1'b1; b_i_addr = 32'(4 * (c - 1)); end
      #1;
      if (c <= 3) begin
        checks++; if (b_i_gnt !== 1'b1 || b_i_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_issue c%0d got=%b%b want=10", c, b_i_gnt, b_i_rvalid); end
      end else if (c <= 6) begin
        checks++; if (b_i_rvalid !== 1'b1 || b_i_rdata !== words[c-4]) begin failures++; $display("FAIL b2b_resp c%0d got=%b %h want=1 %h", c, b_i_rvalid, b_i_rdata, words[c-4]); end
      end else begin
        checks++; if (b_i_rvalid !== 1'b0 || b_i_rdata !== 32'h3333_3333) begin failures++; $display("FAIL b2b_tail got=%b %h want=0 33333333", b_i_rvalid, b_i_rdata); end
      end
    end
  endtask

  task automatic test_alias();
    @(negedge clk); idle_b(); b_d_req = 1'b1; b_d_we = 4'hF; b_d_addr = 32'h40; b_d_wdata = 32'h1234_5678; #1;
    @(negedge clk); b_d_we = 4'h0; b_d_addr = 32'h0; b_d_wdata = 32'h0; #1;
    checks++; if (b_d_gnt !== 1'b1) begin failures++; $display("FAIL alias_read_gnt got=%b want=1", b_d_gnt); end
    @(negedge clk); idle_b(); b_i_req = 1'b1; b_i_addr = 32'h43; #1;
    @(negedge clk); idle_b(); #1;
    checks++; if ({b_d_rvalid, b_i_rvalid} !== 2'b00) begin failures++; $display("FAIL alias_early got=%b want=00", {b_d_rvalid, b_i_rvalid}); end
    @(negedge clk); #1;
    checks++; if (b_d_rvalid !== 1'b1 || b_d_rdata !== 32'h1234_5678) begin failures++; $display("FAIL alias_d got=%b %h want=1 12345678", b_d_rvalid, b_d_rdata); end
    @(negedge clk); #1;
    checks++; if (b_i_rvalid !== 1'b1 || b_i_rdata !== 32'h1234_5678) begin failures++; $display("FAIL alias_i got=%b %h want=1 12345678", b_i_rvalid, b_i_rdata); end
  endtask

  initial begin
    rst = 1'b1; b_rst = 1'b1;
    idle_a(); idle_b();
    test_reset();
    test_ifetch();
    test_byte_enable();
    test_contention();
    test_reset_mid();
    test_back_to_back();
    test_alias();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
